sparse_conv_pe: RTL and testbench
=================================

Name: sparse_conv_pe

Overview:
- Parametrised sparse-convolution processing element for the tracking accelerator.
- Loads a compressed nonzero-weight list (value, in-channel c, out-channel k, row offset r) into an internal buffer.
- Streams compressed nonzero activations (value, row, c); for each activation it scans the weight list, multiplies on channel match, and accumulates into a row x k accumulator array.
- After the last activation, drains accumulators over a valid/ready stream to the output-feature-map writer.

Parameters:
- DATA_W, 16: signed width of activation and weight values.
- ACC_W, 24: signed accumulator / output width (must be >= 2*DATA_W-8; saturating).
- OUT_ROWS, 16: output rows held in the accumulator array.
- OUT_CH, 8: output channels (k) per row.
- IN_CH, 32: input channels; c indices are clog2(IN_CH) bits wide.
- W_DEPTH, 64: weight buffer capacity (entries).
- R_MAX, 4: kernel height; r indices are clog2(R_MAX) bits wide.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  pulse in IDLE: clears accumulators, weight count and overflow flag, enters LOAD_W
- i_w_valid/o_w_ready  in/out  1/1  weight-beat handshake
- i_w_data  in  DATA_W  signed weight value
- i_w_c  in  clog2(IN_CH)  weight input channel
- i_w_k  in  clog2(OUT_CH)  weight output channel
- i_w_r  in  clog2(R_MAX)  weight row offset
- i_w_last  in  1  marks final weight beat
- i_ia_valid/o_ia_ready  in/out  1/1  activation handshake
- i_ia_data  in  DATA_W  signed activation value
- i_ia_row  in  clog2(OUT_ROWS+R_MAX)  activation row
- i_ia_c  in  clog2(IN_CH)  activation channel
- i_ia_last  in  1  marks final activation
- o_out_valid/i_out_ready  out/in  1/1  drain handshake
- o_out_data  out  ACC_W  accumulated value
- o_out_row  out  clog2(OUT_ROWS)  output row
- o_out_k  out  clog2(OUT_CH)  output channel
- o_busy  out  1  high in any state except IDLE
- o_finish  out  1  one-cycle pulse after the last drain beat
- o_w_overflow  out  1  sticky: more than W_DEPTH weights were offered

Behaviour:
- Reset: the state machine returns to IDLE and every output is 0: ready/valid lines, o_out_* fields, o_busy, o_finish and o_w_overflow. Accumulators, weight buffer and counters clear. Reset mid-operation aborts immediately, with no drain.
- States: IDLE -> (i_start) LOAD_W -> (accepted beat with i_w_last) COMPUTE -> (scan of the i_ia_last activation complete) DRAIN -> (final beat accepted) IDLE, with o_finish=1 in the following cycle. i_start outside IDLE is ignored.
- LOAD_W:
  - o_w_ready=1; a beat is accepted when valid&ready.
  - Entries are stored at index w_cnt, and w_cnt increments.
  - Beats arriving at w_cnt==W_DEPTH are dropped and set o_w_overflow, but are still accepted, so i_w_last still advances the state.
- COMPUTE:
  - o_ia_ready=1 only while the scanner is idle.
  - An accepted activation is latched; the scanner visits entries 0..w_cnt-1, one per cycle.
  - Per activation latency: w_cnt cycles, with ready reasserted the cycle after the last entry.
  - Per entry, on a hit (i_w_c==ia_c and 0 <= ia_row-r < OUT_ROWS): acc[ia_row-r][k] += ia*w.
  - The product is full 2*DATA_W signed; the sum saturates to ACC_W min/max.
  - On a miss (channel mismatch or out-of-range row), the accumulator is untouched.
  - Each entry's update is single-cycle, so there are no read-modify-write hazards.
- DRAIN:
  - Beats go out row-major: row 0..OUT_ROWS-1, then k 0..OUT_CH-1, OUT_ROWS*OUT_CH beats in total. Zero accumulators are included.
  - Each beat's data, row and k are held stable while valid&!ready.
- Simultaneous i_start with reset: reset wins.

Decomposition:
- Package sparse_pe_pkg: state enum (S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN), the weight-entry struct typedef, and the saturation-limit constants derived from ACC_W.
- One natural sub-module: sat_mac (signed multiply + saturating add, purely combinational, parametrised by DATA_W/ACC_W).

Test Plan:
- Single entry: w=3 (c=2, k=1, r=0), activation 5 (row 4, c=2, last) -> drain beat (row4, k1)=15, all others 0; o_finish pulses once.
- Channel mismatch: w at c=1, activation at c=2 -> all 128 drain beats are 0.
- Row offset and range: w r=2 with activations at row 1 and row 5, value 7, w=2 -> only (row3, k)=14; the row-1 activation is discarded.
- Saturation: ACC_W=24, w=32767, 300 activations of 32767 on the same row/channel -> output 8388607, not wrapped.
- Backpressure: i_out_ready toggled every other cycle -> 128 beats in row-major order with held data; o_finish after the last beat.
- Overflow and reset: 70 weights into W_DEPTH=64 -> o_w_overflow=1, only the first 64 are used. Asserting i_rst_n=0 mid-COMPUTE -> all outputs 0 and state IDLE; a new i_start then behaves cleanly.

Source files
------------

// File: rtl/sparse_pe_pkg.sv
// sparse_pe_pkg: shared types and constants for the sparse convolution PE.
//   Provides the FSM state enum, the compressed weight-entry record, the default
//   geometry the PE is built around, and the saturation limits derived from ACC_W.
package sparse_pe_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ACC_W_DEF    = 24;
    localparam int OUT_ROWS_DEF = 16;
    localparam int OUT_CH_DEF   = 8;
    localparam int IN_CH_DEF    = 32;
    localparam int W_DEPTH_DEF  = 64;
    localparam int R_MAX_DEF    = 4;

    localparam int C_W = $clog2(IN_CH_DEF);
    localparam int K_W = $clog2(OUT_CH_DEF);
    localparam int R_W = $clog2(R_MAX_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] data;
        logic [C_W-1:0]               c;
        logic [K_W-1:0]               k;
        logic [R_W-1:0]               r;
    } w_entry_t;

    // Largest / smallest value representable in a w-bit signed accumulator.
    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sparse_conv_pe_sat_mac.sv
// sat_mac: combinational signed multiply plus saturating accumulate.
//   a_i, b_i : DATA_W signed operands
//   acc_i    : ACC_W signed running sum
//   sum_o    : acc_i + a_i*b_i clamped to the ACC_W signed range
module sat_mac
    import sparse_pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [ACC_W-1:0]  sum_o
);
    // One guard bit over the wider of product and accumulator so the sum never wraps.
    localparam int SW = ((ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W) + 1;
    localparam logic signed [SW-1:0] MAX = SW'(acc_max(ACC_W));
    localparam logic signed [SW-1:0] MIN = SW'(acc_min(ACC_W));

    logic signed [2*DATA_W-1:0] prod;
    logic signed [SW-1:0]       sum;

    assign prod  = a_i * b_i;
    assign sum   = SW'(prod) + SW'(acc_i);
    assign sum_o = (sum > MAX) ? ACC_W'(MAX) : (sum < MIN) ? ACC_W'(MIN) : ACC_W'(sum);

endmodule

// File: rtl/sparse_conv_pe.sv
// sparse_conv_pe: sparse convolution PE - loads a nonzero weight list, scatters
//   activation x weight products into a row x k accumulator array, then drains it.
//   i_start                      : begin a new job from IDLE
//   i_w_* / o_w_ready            : compressed weight beats (value, c, k, r, last)
//   i_ia_* / o_ia_ready          : compressed activations (value, row, c, last)
//   o_out_* / i_out_ready        : row-major drain of all OUT_ROWS*OUT_CH accumulators
//   o_busy, o_finish, o_w_overflow : status
module sparse_conv_pe
    import sparse_pe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int OUT_ROWS = OUT_ROWS_DEF,
    parameter int OUT_CH   = OUT_CH_DEF,
    parameter int IN_CH    = IN_CH_DEF,
    parameter int W_DEPTH  = W_DEPTH_DEF,
    parameter int R_MAX    = R_MAX_DEF
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_start,
    input  logic                                   i_w_valid,
    output logic                                   o_w_ready,
    input  logic signed [DATA_W-1:0]               i_w_data,
    input  logic [$clog2(IN_CH)-1:0]               i_w_c,
    input  logic [$clog2(OUT_CH)-1:0]              i_w_k,
    input  logic [$clog2(R_MAX)-1:0]               i_w_r,
    input  logic                                   i_w_last,
    input  logic                                   i_ia_valid,
    output logic                                   o_ia_ready,
    input  logic signed [DATA_W-1:0]               i_ia_data,
    input  logic [$clog2(OUT_ROWS+R_MAX)-1:0]      i_ia_row,
    input  logic [$clog2(IN_CH)-1:0]               i_ia_c,
    input  logic                                   i_ia_last,
    output logic                                   o_out_valid,
    input  logic                                   i_out_ready,
    output logic signed [ACC_W-1:0]                o_out_data,
    output logic [$clog2(OUT_ROWS)-1:0]            o_out_row,
    output logic [$clog2(OUT_CH)-1:0]              o_out_k,
    output logic                                   o_busy,
    output logic                                   o_finish,
    output logic                                   o_w_overflow
);
    localparam int CW  = $clog2(IN_CH);
    localparam int KW  = $clog2(OUT_CH);
    localparam int IRW = $clog2(OUT_ROWS + R_MAX);
    localparam int ORW = $clog2(OUT_ROWS);
    localparam int NW  = $clog2(W_DEPTH + 1);
    localparam int IW  = $clog2(W_DEPTH);
    localparam logic [IRW:0] ROWS_LIM = (IRW + 1)'(OUT_ROWS);

    state_t                  state_q;
    w_entry_t                w_buf_q [W_DEPTH];
    logic [NW-1:0]           w_cnt_q;
    logic [IW-1:0]           scan_idx_q;
    logic                    scan_q;
    logic signed [DATA_W-1:0] ia_q;
    logic [IRW-1:0]          ia_row_q;
    logic [CW-1:0]           ia_c_q;
    logic                    ia_last_q;
    logic signed [ACC_W-1:0] acc_q [OUT_ROWS][OUT_CH];
    logic [ORW-1:0]          dr_row_q;
    logic [KW-1:0]           dr_k_q;
    logic                    finish_q;
    logic                    ovf_q;

    w_entry_t                cur;
    logic [IRW:0]            diff;
    logic                    hit;
    logic [ORW-1:0]          hit_row;
    logic                    scan_end;
    logic                    dr_end;
    logic signed [ACC_W-1:0] acc_d;

    // Target row is ia_row - r; the extra MSB of diff is the borrow of a negative row.
    assign cur      = w_buf_q[scan_idx_q];
    assign diff     = {1'b0, ia_row_q} - (IRW + 1)'(cur.r);
    assign hit_row  = diff[ORW-1:0];
    assign hit      = scan_q && (cur.c == ia_c_q) && !diff[IRW] && (diff < ROWS_LIM);
    assign scan_end = (NW'(scan_idx_q) + NW'(1)) == w_cnt_q;
    assign dr_end   = (dr_row_q == ORW'(OUT_ROWS - 1)) && (dr_k_q == KW'(OUT_CH - 1));

    sat_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .a_i   (ia_q),
        .b_i   (cur.data),
        .acc_i (acc_q[hit_row][cur.k]),
        .sum_o (acc_d)
    );

    assign o_w_ready    = state_q == S_LOAD_W;
    assign o_ia_ready   = (state_q == S_COMPUTE) && !scan_q;
    assign o_out_valid  = state_q == S_DRAIN;
    assign o_out_data   = o_out_valid ? acc_q[dr_row_q][dr_k_q] : '0;
    assign o_out_row    = dr_row_q;
    assign o_out_k      = dr_k_q;
    assign o_busy       = state_q != S_IDLE;
    assign o_finish     = finish_q;
    assign o_w_overflow = ovf_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            w_cnt_q    <= '0;
            scan_idx_q <= '0;
            scan_q     <= 1'b0;
            ia_q       <= '0;
            ia_row_q   <= '0;
            ia_c_q     <= '0;
            ia_last_q  <= 1'b0;
            dr_row_q   <= '0;
            dr_k_q     <= '0;
            finish_q   <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < W_DEPTH; i++) w_buf_q[i] <= '0;
            for (int i = 0; i < OUT_ROWS; i++)
                for (int j = 0; j < OUT_CH; j++) acc_q[i][j] <= '0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: if (i_start) begin
                    state_q  <= S_LOAD_W;
                    w_cnt_q  <= '0;
                    ovf_q    <= 1'b0;
                    dr_row_q <= '0;
                    dr_k_q   <= '0;
                    for (int i = 0; i < OUT_ROWS; i++)
                        for (int j = 0; j < OUT_CH; j++) acc_q[i][j] <= '0;
                end
                // Beats beyond capacity are still consumed so the sender's last beat ends the load.
                S_LOAD_W: if (i_w_valid) begin
                    if (w_cnt_q < NW'(W_DEPTH)) begin
                        w_buf_q[w_cnt_q[IW-1:0]] <= '{data: i_w_data, c: i_w_c, k: i_w_k, r: i_w_r};
                        w_cnt_q <= w_cnt_q + NW'(1);
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    if (i_w_last) state_q <= S_COMPUTE;
                end
                S_COMPUTE: if (i_ia_valid && o_ia_ready) begin
                    scan_q     <= 1'b1;
                    scan_idx_q <= '0;
                    ia_q       <= i_ia_data;
                    ia_row_q   <= i_ia_row;
                    ia_c_q     <= i_ia_c;
                    ia_last_q  <= i_ia_last;
                end else if (scan_q) begin
                    if (hit) acc_q[hit_row][cur.k] <= acc_d;
                    if (scan_end) begin
                        scan_q <= 1'b0;
                        if (ia_last_q) state_q <= S_DRAIN;
                    end else begin
                        scan_idx_q <= scan_idx_q + IW'(1);
                    end
                end
                S_DRAIN: if (i_out_ready) begin
                    if (dr_end) begin
                        state_q  <= S_IDLE;
                        finish_q <= 1'b1;
                        dr_row_q <= '0;
                        dr_k_q   <= '0;
                    end else if (dr_k_q == KW'(OUT_CH - 1)) begin
                        dr_k_q   <= '0;
                        dr_row_q <= dr_row_q + ORW'(1);
                    end else begin
                        dr_k_q <= dr_k_q + KW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_conv_pe.sv
// tb_sparse_conv_pe: directed, table-driven self-checking bench for sparse_conv_pe.
module tb_sparse_conv_pe;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_w_valid = 1'b0;
    logic               o_w_ready;
    logic signed [15:0] i_w_data = '0;
    logic [4:0]         i_w_c = '0;
    logic [2:0]         i_w_k = '0;
    logic [1:0]         i_w_r = '0;
    logic               i_w_last = 1'b0;
    logic               i_ia_valid = 1'b0;
    logic               o_ia_ready;
    logic signed [15:0] i_ia_data = '0;
    logic [4:0]         i_ia_row = '0;
    logic [4:0]         i_ia_c = '0;
    logic               i_ia_last = 1'b0;
    logic               o_out_valid;
    logic               i_out_ready = 1'b0;
    logic signed [23:0] o_out_data;
    logic [3:0]         o_out_row;
    logic [2:0]         o_out_k;
    logic               o_busy;
    logic               o_finish;
    logic               o_w_overflow;

    sparse_conv_pe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
        .i_w_c(i_w_c), .i_w_k(i_w_k), .i_w_r(i_w_r), .i_w_last(i_w_last),
        .i_ia_valid(i_ia_valid), .o_ia_ready(o_ia_ready), .i_ia_data(i_ia_data),
        .i_ia_row(i_ia_row), .i_ia_c(i_ia_c), .i_ia_last(i_ia_last),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_row(o_out_row), .o_out_k(o_out_k), .o_busy(o_busy),
        .o_finish(o_finish), .o_w_overflow(o_w_overflow)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int exp_acc [16][8];

    typedef struct {
        int wd, wc, wk, wr;
        int ad, arow, ac;
        int er, ek, ev;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(expv));
        end
    endtask

    function automatic logic [63:0] outs_flat();
        return 64'({o_busy, o_w_ready, o_ia_ready, o_out_valid, o_out_data,
                    o_out_row, o_out_k, o_finish, o_w_overflow});
    endfunction

    task automatic clear_exp();
        foreach (exp_acc[i, j]) exp_acc[i][j] = 0;
    endtask

    task automatic do_start();
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
    endtask

    task automatic send_w(input int d, input int c, input int k, input int r, input bit last);
        int n = 0;
        @(negedge i_clk);
        i_w_valid = 1'b1; i_w_data = 16'(d); i_w_c = 5'(c); i_w_k = 3'(k); i_w_r = 2'(r); i_w_last = last;
        while (!o_w_ready && n < 100) begin @(negedge i_clk); n++; end
        check("w_ready", 64'(o_w_ready), 64'(1));
        @(negedge i_clk);
        i_w_valid = 1'b0; i_w_last = 1'b0;
    endtask

    task automatic send_a(input int d, input int row, input int c, input bit last);
        int n = 0;
        @(negedge i_clk);
        i_ia_valid = 1'b1; i_ia_data = 16'(d); i_ia_row = 5'(row); i_ia_c = 5'(c); i_ia_last = last;
        while (!o_ia_ready && n < 200) begin @(negedge i_clk); n++; end
        check("ia_ready", 64'(o_ia_ready), 64'(1));
        @(negedge i_clk);
        i_ia_valid = 1'b0; i_ia_last = 1'b0;
    endtask

    // Collects all 128 drain beats, checking order, data against exp_acc, and hold-under-stall.
    task automatic drain_check(input string tag, input bit bp);
        int beat = 0;
        int cyc = 0;
        bit holding = 1'b0;
        logic [63:0] held = '0;
        while (beat < 128 && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            if (holding) begin
                check($sformatf("%s_hold%0d", tag, beat), outs_flat(), held);
                holding = 1'b0;
            end
            i_out_ready = bp ? (cyc % 2 == 1) : 1'b1;
            if (o_out_valid) begin
                if (i_out_ready) begin
                    check($sformatf("%s_row%0d", tag, beat), 64'(o_out_row), 64'(beat / 8));
                    check($sformatf("%s_k%0d", tag, beat), 64'(o_out_k), 64'(beat % 8));
                    check($sformatf("%s_data%0d", tag, beat), $signed(o_out_data),
                          64'(exp_acc[beat / 8][beat % 8]));
                    beat++;
                end else begin
                    holding = 1'b1;
                    held = outs_flat();
                end
            end
        end
        check({tag, "_beats"}, 64'(beat), 64'(128));
        @(negedge i_clk);
        i_out_ready = 1'b0;
        check({tag, "_finish"}, 64'(o_finish), 64'(1));
        @(negedge i_clk);
        check({tag, "_finish_pulse"}, 64'({o_finish, o_busy}), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        do_start();
        send_w(v.wd, v.wc, v.wk, v.wr, 1'b1);
        send_a(v.ad, v.arow, v.ac, 1'b1);
        clear_exp();
        if (v.er >= 0) exp_acc[v.er][v.ek] = v.ev;
        drain_check($sformatf("vec%0d", idx), 1'b0);
    endtask

    task automatic load_overflow();
        for (int i = 0; i < 70; i++) begin
            if (i < 64) send_w(1, 0, i % 8, 0, 1'b0);
            else send_w(100, 0, 0, 0, i == 69);
            if (i == 63) check("ovf_at_64", 64'(o_w_overflow), 64'(0));
            if (i == 64) check("ovf_at_65", 64'(o_w_overflow), 64'(1));
        end
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{3, 2, 1, 0, 5, 4, 2, 4, 1, 15};
        vecs[1] = '{3, 1, 1, 0, 5, 4, 2, -1, 0, 0};
        vecs[2] = '{-4, 0, 7, 3, 6, 18, 0, 15, 7, -24};
        vecs[3] = '{2, 31, 0, 3, -7, 3, 31, 0, 0, -14};
        vecs[4] = '{2, 5, 2, 1, 7, 17, 5, -1, 0, 0};
        vecs[5] = '{-32768, 3, 4, 0, -32768, 0, 3, 0, 4, 8388607};
        vecs[6] = '{-32768, 3, 4, 0, 32767, 0, 3, 0, 4, -8388608};

        repeat (3) @(negedge i_clk);
        check("reset_outs", outs_flat(), 64'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_outs", outs_flat(), 64'(0));

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Row offset with one out-of-range activation, stray start in COMPUTE, stalled drain.
        do_start();
        send_w(2, 9, 5, 2, 1'b1);
        do_start();
        check("start_ignored", 64'({o_busy, o_ia_ready}), 64'(3));
        send_a(7, 1, 9, 1'b0);
        send_a(7, 5, 9, 1'b1);
        clear_exp();
        exp_acc[3][5] = 14;
        drain_check("rowoff_bp", 1'b1);

        // Accumulation saturation over many activations.
        do_start();
        send_w(32767, 0, 0, 0, 1'b0);
        send_w(1, 0, 1, 0, 1'b1);
        for (int i = 0; i < 300; i++) send_a(32767, 0, 0, i == 299);
        clear_exp();
        exp_acc[0][0] = 8388607;
        exp_acc[0][1] = 8388607;
        drain_check("sat", 1'b0);

        // Overflowing weight load: only the first 64 entries contribute.
        do_start();
        load_overflow();
        send_a(1, 0, 0, 1'b1);
        clear_exp();
        for (int k = 0; k < 8; k++) exp_acc[0][k] = 8;
        drain_check("ovf", 1'b0);

        // Asynchronous reset in the middle of a scan, then a clean job.
        do_start();
        load_overflow();
        send_a(1, 0, 0, 1'b0);
        repeat (3) @(negedge i_clk);
        check("busy_before_rst", 64'({o_busy, o_w_overflow}), 64'(3));
        i_rst_n = 1'b0;
        #1;
        check("midrst_outs", outs_flat(), 64'(0));
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post_rst_idle", outs_flat(), 64'(0));
        run_vec(vecs[0], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
